byte_word_packer: RTL

//  Packs an 8-bit byte stream into 16-bit words and buffers them in a single-clock FWFT FIFO.

---
 rtl/pack_pkg.sv | 13 +
 rtl/sc_word_fifo.sv | 68 ++++++
 rtl/byte_word_packer.sv | 79 +++++++
 3 files changed

// File: rtl/pack_pkg.sv
// Shared widths and constants for the byte-to-word packer.
package pack_pkg;
  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 16;
  localparam int DEPTH_DEF = 16;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  // First byte of a pair lands in the low half of the word.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/sc_word_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// The head register is loaded with the word that will be at the front after
// each edge, so rdata is a flop output rather than a RAM read path.
module sc_word_fifo
  import pack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic [AW:0]       usedw,
  output logic              full,
  output logic              empty
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       left;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign usedw = count_q;
  assign rdata = rdata_q;

  // Next pointers, occupancy and head word.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    left     = count_q - (AW+1)'(do_pop);
    rdata_d  = rdata_q;
    if (count_d != '0) begin
      // Nothing older survives the pop: the incoming word becomes the head.
      if (left == '0) rdata_d = wdata;
      else            rdata_d = mem_q[rd_ptr_d];
    end
  end

  // Control state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/byte_word_packer.sv
// Byte stream to 16-bit word packer feeding a FWFT word FIFO.
// Optional feature macro: PACK_FLUSH_EN (flush pads a held odd byte with
// PAD_BYTE and pushes it). Without the macro, flush is ignored.
module byte_word_packer
  import pack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic [AW:0]       usedw,
  output logic              full,
  output logic              odd_held
);
  logic [BYTE_W-1:0] lo_byte_q, lo_byte_d;
  logic              odd_held_q, odd_held_d;
  logic              accept, push, flush_push, fifo_empty;
  logic [WORD_W-1:0] wdata;

`ifdef PACK_FLUSH_EN
  assign flush_push = flush && odd_held_q && !full;
  assign in_ready   = !flush && !(odd_held_q && full);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_push   = 1'b0;
  assign in_ready     = !(odd_held_q && full);
`endif

  assign odd_held  = odd_held_q;
  assign out_valid = !fifo_empty;

  // Hold register update and word assembly.
  always_comb begin
    accept     = in_valid && in_ready;
    push       = (accept && odd_held_q) || flush_push;
    wdata      = flush_push ? pack_word(PAD_BYTE, lo_byte_q)
                            : pack_word(in_data, lo_byte_q);
    lo_byte_d  = lo_byte_q;
    odd_held_d = odd_held_q;
    if (accept) begin
      if (!odd_held_q) lo_byte_d = in_data;
      odd_held_d = !odd_held_q;
    end else if (flush_push) begin
      odd_held_d = 1'b0;
    end
  end

  // Hold register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte_q  <= '0;
      odd_held_q <= 1'b0;
    end else begin
      lo_byte_q  <= lo_byte_d;
      odd_held_q <= odd_held_d;
    end
  end

  sc_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (out_ready),
    .rdata (out_data),
    .usedw (usedw),
    .full  (full),
    .empty (fifo_empty)
  );
endmodule
